// File: rtl/vfetch_pkg.sv
// vfetch_pkg: shared defaults, FSM state type and occupancy width for the vertex fetch block
package vfetch_pkg;
  localparam int VF_ADDR_W = 8;
  localparam int VF_DATA_W = 128;
  localparam int VF_FIFO_D = 4;
  localparam int VF_OCC_W = $clog2(VF_FIFO_D) + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} vf_state_t;
endpackage

// File: rtl/vfetch_fifo.sv
// vfetch_fifo: synchronous first-word-fall-through FIFO
// Ports: clk, rst_n (sync, active low), push/din write side, pop/dout read side,
//        full/empty/count status. dout reads 0 while empty.
module vfetch_fifo #(
  parameter int DW = 128,
  parameter int D = 4,
  parameter int CW = $clog2(D) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(D);
  logic [DW-1:0] mem [D];
  logic [PW-1:0] wp, rp;
  assign empty = count == '0;
  assign full = count == CW'(D);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= push ? wp + PW'(1) : wp;
      rp <= pop ? rp + PW'(1) : rp;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/vertex_fetch.sv
// vertex_fetch: streams a contiguous run of vertices from vertex memory to a valid/ready consumer
// Ports: start/base_addr/vcount request (plus stride when VFETCH_STRIDE_EN is defined),
//        busy/done status, mem_addr/mem_we/mem_rdata memory port (1-cycle read latency),
//        vert_valid/vert_ready/vert_data downstream handshake. rst_n is sync active low.
// mem_addr doubles as the read pointer: the memory samples it on the issuing edge, after which it advances.
module vertex_fetch
  import vfetch_pkg::*;
#(
  parameter int ADDR_W = VF_ADDR_W,
  parameter int DATA_W = VF_DATA_W,
  parameter int FIFO_D = VF_FIFO_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   vcount,
`ifdef VFETCH_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vert_valid,
  input  logic              vert_ready,
  output logic [DATA_W-1:0] vert_data
);
  localparam int CW = $clog2(FIFO_D) + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_D);
  vf_state_t state;
  logic [ADDR_W:0] remaining;
  logic [ADDR_W-1:0] step;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic inflight, issue, pop, full, empty;
`ifdef VFETCH_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif
  assign mem_we = 1'b0;
  assign vert_valid = !empty;
  assign pop = vert_valid & vert_ready;
  // credit includes the word still in flight from memory
  assign occ = {1'b0, count} + (CW+1)'(inflight);
  assign issue = state == FETCH && !full && occ < DEPTH;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_addr <= '0;
      remaining <= '0;
      inflight <= 1'b0;
`ifdef VFETCH_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      inflight <= issue;
      case (state)
        IDLE:
          if (start && vcount == '0) done <= 1'b1;
          else if (start) begin
            state <= FETCH;
            busy <= 1'b1;
            mem_addr <= base_addr;
            remaining <= vcount;
`ifdef VFETCH_STRIDE_EN
            stride_q <= stride;
`endif
          end
        FETCH:
          if (issue) begin
            mem_addr <= mem_addr + step;
            remaining <= remaining - (ADDR_W+1)'(1);
            state <= remaining == (ADDR_W+1)'(1) ? DRAIN : FETCH;
          end
        DRAIN:
          if (!inflight && count == CW'(1) && pop) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
  vfetch_fifo #(.DW(DATA_W), .D(FIFO_D)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight),
    .pop(pop),
    .din(mem_rdata),
    .dout(vert_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_vertex_fetch.sv
// tb_vertex_fetch: randomized self-checking bench for vertex_fetch against a queue-based model
module tb_vertex_fetch;
  logic clk = 1'b0;
  logic rst_n, start, busy, done, mem_we, vert_valid, vert_ready;
  logic [7:0] base_addr, mem_addr, stride;
  logic [8:0] vcount;
  logic [127:0] mem_rdata, vert_data;
  logic [127:0] mem [256];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  vertex_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .vcount(vcount),
`ifdef VFETCH_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .vert_valid(vert_valid),
    .vert_ready(vert_ready),
    .vert_data(vert_data)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for the first 10 cycles
  task automatic run_job(input logic [7:0] b, input logic [8:0] n, input logic [7:0] s,
                         input int mode, input int lat_exp);
    logic [127:0] q[$];
    logic [127:0] prev_d = '0;
    logic prev_stall = 1'b0;
    logic [7:0] st = s;
    int first_v = -1, last_hs = -1, done_at = -1, done_cnt = 0, extra = 0;
`ifndef VFETCH_STRIDE_EN
    st = 8'd1;
`endif
    for (int i = 0; i < int'(n); i++) q.push_back(mem[(int'(b) + i * int'(st)) % 256]);
    base_addr = b;
    vcount = n;
    stride = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 4000 && !(done_cnt > 0 && c > done_at + 2); c++) begin
      vert_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'(c > 10);
      if (c == 5 && busy) begin
        start = 1'b1;
        base_addr = 8'($urandom);
        vcount = 9'($urandom_range(1, 30));
        stride = 8'($urandom);
      end
      if (c == 6) start = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      if (prev_stall) begin
        chk("hold_valid", 128'(vert_valid), 128'(1));
        chk("hold_data", vert_data, prev_d);
      end
      if (mode == 2 && c == 10) chk("bp_reads_issued", 128'(mem_addr), 128'(8'(b + 8'd4)));
      if (vert_valid && first_v < 0) first_v = c;
      if (vert_valid && vert_ready) begin
        if (q.size() == 0) extra++;
        else begin
          chk("data", vert_data, q.pop_front());
          last_hs = c;
        end
      end
      prev_stall = vert_valid && !vert_ready;
      prev_d = vert_data;
      @(negedge clk);
    end
    chk("words_left", 128'(q.size()), 128'(0));
    chk("extra_words", 128'(extra), 128'(0));
    chk("done_count", 128'(done_cnt), 128'(1));
    chk("done_after_last", 128'(done_at), 128'(last_hs + 1));
    chk("busy_end", 128'(busy), 128'(0));
    if (lat_exp > 0) chk("first_valid_latency", 128'(first_v), 128'(lat_exp));
  endtask

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    vcount = '0;
    stride = 8'd1;
    vert_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(vert_valid), 128'(0));
    chk("rst_addr", 128'(mem_addr), 128'(0));
    chk("rst_we", 128'(mem_we), 128'(0));
    chk("rst_data", vert_data, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    run_job(8'h10, 9'd4, 8'd1, 0, 3);
    run_job(8'h20, 9'd8, 8'd1, 2, 0);
    run_job(8'hFE, 9'd4, 8'd1, 1, 0);
    run_job(8'h80, 9'd256, 8'd1, 1, 0);
    a = mem_addr;
    base_addr = 8'h55;
    vcount = 9'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 128'(done), 128'(1));
    chk("zero_busy", 128'(busy), 128'(0));
    chk("zero_addr", 128'(mem_addr), 128'(a));
    chk("zero_valid", 128'(vert_valid), 128'(0));
    @(negedge clk);
    chk("zero_done_end", 128'(done), 128'(0));
    base_addr = 8'h40;
    vcount = 9'd20;
    vert_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    chk("mid_rst_valid", 128'(vert_valid), 128'(0));
    chk("mid_rst_addr", 128'(mem_addr), 128'(0));
    chk("mid_rst_data", vert_data, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 128'(done), 128'(0));
    run_job(8'h00, 9'd2, 8'd1, 1, 0);
    run_job(8'h00, 9'd3, 8'd3, 1, 0);
    repeat (4) run_job(8'($urandom), 9'($urandom_range(1, 40)), 8'($urandom), 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
